// File: rtl/quad_encoder_gen.sv
//------------------------------------------------------------------------------
// Module   : quad_encoder_gen
// Brief    : Quadrature A/B and pushbutton stimulus generator (encoder TX side).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module quad_encoder_gen #(
  parameter int STEP_DIV     = 4,
  parameter int SHORT_CYCLES = 8,
  parameter int LONG_CYCLES  = 32,
  parameter int GAP_CYCLES   = 8,
  parameter int TIMER_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [3:0] cmd_steps,
  input  logic [1:0] cmd_pb,
  output logic       a,
  output logic       b,
  output logic       pb,
  output logic       busy,
  output logic [3:0] steps_left,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROTATE = 3'd1,
    S_PRESS  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] c_PB_NONE   = 2'b00;
  localparam logic [1:0] c_PB_LONG   = 2'b10;
  localparam logic [1:0] c_PB_DOUBLE = 2'b11;

  localparam logic [TIMER_W-1:0] c_STEP_LAST  = TIMER_W'(STEP_DIV - 1);
  localparam logic [TIMER_W-1:0] c_SHORT_LAST = TIMER_W'(SHORT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_LONG_LAST  = TIMER_W'(LONG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] c_GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [1:0]         r_phase;
  logic               r_dir;
  logic [1:0]         r_pb_mode;
  logic               r_second;
  logic               r_a;
  logic               r_b;
  logic               r_pb;
  logic               r_done;
  logic [3:0]         r_steps_left;

  logic [TIMER_W-1:0] w_press_last;
  logic [1:0]         w_next_ab;

  // Gray-coded detent cycle; index 3 is always the 00 rest state.
  function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] phase);
    logic [1:0] ab;
    ab = 2'b00;
    case (phase)
      2'd0:    ab = dir ? 2'b01 : 2'b10;
      2'd1:    ab = 2'b11;
      2'd2:    ab = dir ? 2'b10 : 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  assign w_press_last = ((r_pb_mode == c_PB_LONG) && !r_second) ? c_LONG_LAST : c_SHORT_LAST;
  assign w_next_ab    = phase_ab(r_dir, r_phase + 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_phase      <= 2'd0;
      r_dir        <= 1'b0;
      r_pb_mode    <= c_PB_NONE;
      r_second     <= 1'b0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_pb         <= 1'b0;
      r_done       <= 1'b0;
      r_steps_left <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_dir        <= cmd_dir;
            r_pb_mode    <= cmd_pb;
            r_second     <= 1'b0;
            r_timer      <= '0;
            r_phase      <= 2'd0;
            r_steps_left <= cmd_steps;
            if (cmd_steps != 4'd0) begin
              r_state      <= S_ROTATE;
              {r_a, r_b}   <= phase_ab(cmd_dir, 2'd0);
            end else if (cmd_pb != c_PB_NONE) begin
              r_state <= S_PRESS;
              r_pb    <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_ROTATE: begin
          if (r_timer == c_STEP_LAST) begin
            r_timer <= '0;
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd3) begin
              if (r_steps_left != 4'd0) begin
                r_steps_left <= r_steps_left - 4'd1;
              end
              // Last detent: a/b already rest at 00, move on to the press or finish.
              if (r_steps_left <= 4'd1) begin
                if (r_pb_mode != c_PB_NONE) begin
                  r_state <= S_PRESS;
                  r_pb    <= 1'b1;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end
              end else begin
                {r_a, r_b} <= w_next_ab;
              end
            end else begin
              {r_a, r_b} <= w_next_ab;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_PRESS: begin
          if (r_timer == w_press_last) begin
            r_timer <= '0;
            r_pb    <= 1'b0;
            r_state <= S_GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_GAP: begin
          if (r_timer == c_GAP_LAST) begin
            r_timer <= '0;
            if ((r_pb_mode == c_PB_DOUBLE) && !r_second) begin
              r_second <= 1'b1;
              r_pb     <= 1'b1;
              r_state  <= S_PRESS;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign a          = r_a;
  assign b          = r_b;
  assign pb         = r_pb;
  assign done       = r_done;
  assign steps_left = r_steps_left;

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_quad_encoder_gen
// Brief    : Scoreboard bench for quad_encoder_gen: expected output-change trace.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_quad_encoder_gen;

  localparam int SD = 4;
  localparam int SH = 8;
  localparam int LG = 32;
  localparam int GP = 8;

  // Observed vector: {a,b,pb,steps_left[3:0],busy,done,cmd_ready}
  localparam logic [9:0] c_IDLE = 10'b00_0_0000_0_0_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_steps = 4'd0;
  logic [1:0] cmd_pb = 2'd0;
  logic       a, b, pb, busy, done;
  logic [3:0] steps_left;

  quad_encoder_gen #(
    .STEP_DIV(SD), .SHORT_CYCLES(SH), .LONG_CYCLES(LG), .GAP_CYCLES(GP), .TIMER_W(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_pb(cmd_pb),
    .a(a), .b(b), .pb(pb), .busy(busy), .steps_left(steps_left), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [9:0] v;
  } ev_t;

  ev_t        q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [9:0] exp_prev = c_IDLE;
  logic [9:0] obs_prev = c_IDLE;
  bit         mon_en = 1'b0;
  bit         pend = 1'b0;
  int         k = 0;

  function automatic logic [1:0] seq(input bit dir, input int p);
    logic [1:0] cw[4];
    logic [1:0] ccw[4];
    cw  = '{2'b10, 2'b11, 2'b01, 2'b00};
    ccw = '{2'b01, 2'b11, 2'b10, 2'b00};
    return dir ? ccw[p] : cw[p];
  endfunction

  task automatic push_ev(input int t, input logic [9:0] v);
    ev_t e;
    if (v !== exp_prev) begin
      e.t = t;
      e.v = v;
      q.push_back(e);
      exp_prev = v;
    end
  endtask

  // Expected output trace, cycle kk = kk-th cycle after the accept edge.
  // kcut > 0: reset lands so that cycle kcut+1 already shows the idle state.
  task automatic gen(input bit dir, input int s, input int pm, input int kcut);
    int R, P, T, len1, x;
    logic [1:0] ab;
    logic       p, bz, dn;
    logic [3:0] sl;
    R    = 4 * SD * s;
    P    = (pm == 0) ? 0 : (pm == 1) ? SH + GP : (pm == 2) ? LG + GP : 2 * (SH + GP);
    T    = R + P + 2;
    len1 = (pm == 2) ? LG : SH;
    for (int kk = 1; kk <= T; kk++) begin
      if (kcut > 0 && kk > kcut) begin
        push_ev(kk, c_IDLE);
        break;
      end
      ab = 2'b00; p = 1'b0; sl = 4'd0; bz = 1'b1; dn = 1'b0;
      if (kk <= R) begin
        ab = seq(dir, ((kk - 1) % (4 * SD)) / SD);
        sl = 4'(s - (kk - 1) / (4 * SD));
      end else if (kk <= R + P) begin
        x = kk - R - 1;
        if (x < len1) p = 1'b1;
        else if (x >= len1 + GP && x < len1 + GP + SH) p = 1'b1;
      end else if (kk == R + P + 1) begin
        dn = 1'b1;
      end else begin
        bz = 1'b0;
      end
      push_ev(kk, {ab, p, sl, bz, dn, ~bz});
    end
  endtask

  // Monitor: every change on the DUT outputs pops one expected event.
  always @(negedge clk) begin
    logic [9:0] cur;
    ev_t        e;
    if (mon_en) begin
      k    = pend ? 1 : k + 1;
      pend = 1'b0;
      cur  = {a, b, pb, steps_left, busy, done, cmd_ready};
      if (cur !== obs_prev) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: actual t=%0d v=%b, required no change from %b",
                   k, cur, obs_prev);
        end else begin
          e = q.pop_front();
          if (e.t == k && e.v === cur) n_pass++;
          else $display("FAIL trace_event: actual t=%0d v=%b, required t=%0d v=%b",
                        k, cur, e.t, e.v);
        end
        obs_prev = cur;
      end
      if (cmd_valid && cmd_ready && !rst) pend = 1'b1;
    end
  end

  task automatic send(input bit dir, input int s, input int pm);
    gen(dir, s, pm, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = 4'(s); cmd_pb = 2'(pm);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      n_total++;
      $display("FAIL drain_timeout: actual pending=%0d busy=%0b, required pending=0 busy=0",
               q.size(), busy);
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [9:0] cur;
    int         n;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cur = {a, b, pb, steps_left, busy, done, cmd_ready};
    n_total++;
    if (cur === c_IDLE) n_pass++;
    else $display("FAIL reset_state: actual v=%b, required v=%b", cur, c_IDLE);
    mon_en = 1'b1;

    send(1'b0, 2, 0);  wait_idle();   // CW 2 steps, done at +33
    send(1'b1, 1, 2);  wait_idle();   // CCW 1 step + long press, done at +57
    send(1'b0, 0, 3);  wait_idle();   // double press only, done at +33
    send(1'b0, 0, 0);  wait_idle();   // empty command, done at +1
    send(1'b1, 3, 1);  wait_idle();   // CCW 3 steps + short press

    // cmd_valid held high: second command only in first IDLE cycle after done
    gen(1'b0, 1, 1, 0);
    gen(1'b1, 1, 0, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 4'd1; cmd_pb = 2'b01;
    @(posedge clk); #1;
    cmd_dir = 1'b1; cmd_steps = 4'd1; cmd_pb = 2'b00;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
    end
    if (n >= 300) begin
      n_total++;
      $display("FAIL handshake_timeout: actual cmd_ready=%0b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle();

    // Reset while {a,b}=11 in the first CW step
    gen(1'b0, 3, 0, 5);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 4'd3; cmd_pb = 2'b00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();

    send(1'b0, 1, 1);  wait_idle();   // fresh command after abort

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running, required finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
